// File: rtl/p2m_pack_indication_deser.sv
// p2m_pack_indication_deser
//   Receive side of the PackIndication method-to-pipe packer. Collects
//   32-bit beats from a PipeIn-style enq stream, checks the header, rebuilds
//   one heard() call and offers it on a PackIndication client port.
//   Messages whose header does not match are skipped in full and counted
//   in a saturating error counter.
//
// Ports
//   CLK                in   clock, all logic on rising edge
//   nRST               in   synchronous reset, active-high
//   pipe_enq__ENA      in   beat valid
//   pipe_enq_v         in   beat data [31:0]
//   pipe_enq__RDY      out  beat may be accepted (decoded from state only)
//   heard__ENA         out  call valid
//   heard_v            out  payload word [31:0]
//   heard_write_count  out  write count [15:0]
//   heard_read_count   out  read count [15:0]
//   heard_seqno        out  sequence number [31:0]
//   heard__RDY         in   sink accepts call
//   err_count          out  dropped-message count [ERR_W-1:0], saturating
//
// State | meaning
// ------+-------------------------------------------------------------
// HDR   | waiting for a header beat
// PAY   | collecting payload beats of an accepted message
// DELIV | call presented on heard port, input stalled
// DROP  | swallowing the remaining beats of a rejected message

module p2m_pack_indication_deser #(
  parameter logic [15:0] METHOD_ID = 16'd3,
  parameter logic [15:0] MSG_BEATS = 16'd5,
  parameter int          ERR_W     = 8
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             pipe_enq__ENA,
  input  logic [31:0]      pipe_enq_v,
  output logic             pipe_enq__RDY,
  output logic             heard__ENA,
  output logic [31:0]      heard_v,
  output logic [15:0]      heard_write_count,
  output logic [15:0]      heard_read_count,
  output logic [31:0]      heard_seqno,
  input  logic             heard__RDY,
  output logic [ERR_W-1:0] err_count
);

  typedef enum logic [1:0] {
    HDR   = 2'd0,
    PAY   = 2'd1,
    DELIV = 2'd2,
    DROP  = 2'd3
  } state_t;

  localparam logic [ERR_W-1:0] ERR_ONE = {{(ERR_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [15:0]      beat_cnt_q, beat_cnt_d;
  logic [15:0]      remaining_q, remaining_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;
  logic [31:0]      v_q, v_d;
  logic [15:0]      wc_q, wc_d;
  logic [15:0]      rc_q, rc_d;
  logic [31:0]      seqno_q, seqno_d;

  logic             rdy;
  logic             accept;
  logic [15:0]      hdr_len;
  logic [15:0]      hdr_id;
  logic [ERR_W-1:0] err_inc;

  assign hdr_len = pipe_enq_v[31:16];
  assign hdr_id  = pipe_enq_v[15:0];

  // Saturate instead of wrapping so a flood of bad headers stays visible.
  assign err_inc = (err_count_q == {ERR_W{1'b1}}) ? err_count_q : err_count_q + ERR_ONE;

  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    remaining_d = remaining_q;
    err_count_d = err_count_q;
    v_d         = v_q;
    wc_d        = wc_q;
    rc_d        = rc_q;
    seqno_d     = seqno_q;

    // Ready depends on state alone, so heard__RDY never reaches pipe_enq__RDY.
    rdy    = (state_q != DELIV);
    accept = pipe_enq__ENA & rdy;

    unique case (state_q)
      HDR: begin
        if (accept) begin
          if (hdr_id == METHOD_ID && hdr_len == MSG_BEATS) begin
            state_d    = PAY;
            beat_cnt_d = 16'd1;
          end else if (hdr_len <= 16'd1) begin
            // Header-only message: nothing left to skip.
            err_count_d = err_inc;
          end else begin
            state_d     = DROP;
            remaining_d = hdr_len - 16'd1;
            err_count_d = err_inc;
          end
        end
      end

      PAY: begin
        if (accept) begin
          case (beat_cnt_q)
            16'd1: v_d = pipe_enq_v;
            16'd2: begin
              wc_d = pipe_enq_v[31:16];
              rc_d = pipe_enq_v[15:0];
            end
            16'd3: seqno_d = pipe_enq_v;
            default: ;
          endcase
          beat_cnt_d = beat_cnt_q + 16'd1;
          if (beat_cnt_q == MSG_BEATS - 16'd1) begin
            state_d = DELIV;
          end
        end
      end

      DELIV: begin
        if (heard__RDY) begin
          state_d = HDR;
        end
      end

      DROP: begin
        if (accept) begin
          remaining_d = remaining_q - 16'd1;
          if (remaining_q == 16'd1) begin
            state_d = HDR;
          end
        end
      end

      default: state_d = HDR;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (nRST) begin
      state_q     <= HDR;
      beat_cnt_q  <= 16'd0;
      remaining_q <= 16'd0;
      err_count_q <= '0;
      v_q         <= 32'd0;
      wc_q        <= 16'd0;
      rc_q        <= 16'd0;
      seqno_q     <= 32'd0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      remaining_q <= remaining_d;
      err_count_q <= err_count_d;
      v_q         <= v_d;
      wc_q        <= wc_d;
      rc_q        <= rc_d;
      seqno_q     <= seqno_d;
    end
  end

  assign pipe_enq__RDY     = rdy;
  assign heard__ENA        = (state_q == DELIV);
  assign heard_v           = v_q;
  assign heard_write_count = wc_q;
  assign heard_read_count  = rc_q;
  assign heard_seqno       = seqno_q;
  assign err_count         = err_count_q;

endmodule

// File: tb/tb_p2m_pack_indication_deser.sv
// Directed bench for p2m_pack_indication_deser.
module tb_p2m_pack_indication_deser;

  logic        CLK = 1'b0;
  logic        nRST = 1'b1;
  logic        pipe_enq__ENA = 1'b0;
  logic [31:0] pipe_enq_v = 32'd0;
  logic        pipe_enq__RDY;
  logic        heard__ENA;
  logic [31:0] heard_v;
  logic [15:0] heard_write_count;
  logic [15:0] heard_read_count;
  logic [31:0] heard_seqno;
  logic        heard__RDY = 1'b1;
  logic [7:0]  err_count;

  int checks = 0;
  int failures = 0;
  int fire_count = 0;
  int fires_before;

  p2m_pack_indication_deser dut (
    .CLK               (CLK),
    .nRST              (nRST),
    .pipe_enq__ENA     (pipe_enq__ENA),
    .pipe_enq_v        (pipe_enq_v),
    .pipe_enq__RDY     (pipe_enq__RDY),
    .heard__ENA        (heard__ENA),
    .heard_v           (heard_v),
    .heard_write_count (heard_write_count),
    .heard_read_count  (heard_read_count),
    .heard_seqno       (heard_seqno),
    .heard__RDY        (heard__RDY),
    .err_count         (err_count)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (!nRST && heard__ENA && heard__RDY) fire_count++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic send_beat(input logic [31:0] d);
    pipe_enq__ENA = 1'b1;
    pipe_enq_v    = d;
    @(posedge CLK);
    #1;
    pipe_enq__ENA = 1'b0;
    pipe_enq_v    = 32'd0;
  endtask

  task automatic do_reset();
    nRST = 1'b1;
    @(posedge CLK);
    #1;
    nRST = 1'b0;
  endtask

  task automatic send_test1_msg();
    send_beat(32'h0005_0003);
    send_beat(32'hDEAD_BEEF);
    send_beat(32'h0007_0009);
    send_beat(32'h0000_0042);
    send_beat(32'h0000_0000);
  endtask

  task automatic check_call(input string tag);
    check({tag, "_ena"},   {31'd0, heard__ENA},        32'd1);
    check({tag, "_rdy"},   {31'd0, pipe_enq__RDY},     32'd0);
    check({tag, "_v"},     heard_v,                    32'hDEAD_BEEF);
    check({tag, "_wc"},    {16'd0, heard_write_count}, 32'd7);
    check({tag, "_rc"},    {16'd0, heard_read_count},  32'd9);
    check({tag, "_seqno"}, heard_seqno,                32'h0000_0042);
  endtask

  initial begin
    // Reset state
    @(posedge CLK);
    @(posedge CLK);
    #1;
    nRST = 1'b0;
    check("rst_rdy", {31'd0, pipe_enq__RDY}, 32'd1);
    check("rst_ena", {31'd0, heard__ENA},    32'd0);
    check("rst_err", {24'd0, err_count},     32'd0);
    check("rst_v",   heard_v,                32'd0);
    check("rst_seq", heard_seqno,            32'd0);

    // Idle cycles with ENA low change nothing
    @(posedge CLK);
    @(posedge CLK);
    #1;
    check("idle_ena", {31'd0, heard__ENA}, 32'd0);

    // Test 1: back-to-back message, sink ready
    fires_before = fire_count;
    heard__RDY = 1'b1;
    send_test1_msg();
    check_call("t1");
    check("t1_err", {24'd0, err_count}, 32'd0);
    @(posedge CLK);
    #1;
    check("t1_ena_after", {31'd0, heard__ENA},    32'd0);
    check("t1_rdy_after", {31'd0, pipe_enq__RDY}, 32'd1);
    check("t1_fires", fire_count - fires_before, 32'd1);

    // Test 2: sink stalls 3 cycles, accepts in the 4th
    fires_before = fire_count;
    heard__RDY = 1'b0;
    send_test1_msg();
    for (int i = 0; i < 3; i++) begin
      check_call("t2_stall");
      @(posedge CLK);
      #1;
    end
    check_call("t2_c4");
    check("t2_fires_held", fire_count - fires_before, 32'd0);
    heard__RDY = 1'b1;
    @(posedge CLK);
    #1;
    check("t2_ena_after", {31'd0, heard__ENA}, 32'd0);
    check("t2_fires", fire_count - fires_before, 32'd1);

    // Test 3: foreign 4-beat message dropped, then a good one
    do_reset();
    fires_before = fire_count;
    send_beat(32'h0004_0007);
    check("t3_err_hdr", {24'd0, err_count}, 32'd1);
    send_beat(32'h1111_1111);
    send_beat(32'h2222_2222);
    send_beat(32'h3333_3333);
    check("t3_rdy_hdr", {31'd0, pipe_enq__RDY}, 32'd1);
    check("t3_ena_none", {31'd0, heard__ENA}, 32'd0);
    send_test1_msg();
    check_call("t3");
    check("t3_err", {24'd0, err_count}, 32'd1);
    @(posedge CLK);
    #1;
    check("t3_fires", fire_count - fires_before, 32'd1);

    // Test 4: len=1 header, no beats skipped
    do_reset();
    fires_before = fire_count;
    send_beat(32'h0001_0003);
    check("t4_err", {24'd0, err_count}, 32'd1);
    send_test1_msg();
    check_call("t4");
    @(posedge CLK);
    #1;
    check("t4_fires", fire_count - fires_before, 32'd1);
    check("t4_err_end", {24'd0, err_count}, 32'd1);

    // Test 5: reset mid-message discards the partial
    fires_before = fire_count;
    send_beat(32'h0005_0003);
    send_beat(32'hDEAD_BEEF);
    send_beat(32'h0007_0009);
    do_reset();
    check("t5_rdy", {31'd0, pipe_enq__RDY}, 32'd1);
    check("t5_ena", {31'd0, heard__ENA},    32'd0);
    check("t5_v0",  heard_v,                32'd0);
    check("t5_err0", {24'd0, err_count},    32'd0);
    send_test1_msg();
    check_call("t5");
    @(posedge CLK);
    #1;
    check("t5_fires", fire_count - fires_before, 32'd1);
    check("t5_err", {24'd0, err_count}, 32'd0);

    // Test 6: err_count saturates at 255
    do_reset();
    for (int i = 1; i <= 300; i++) begin
      send_beat(32'h0001_0000);
      if (i == 254) check("t6_err_254", {24'd0, err_count}, 32'd254);
      if (i == 255) check("t6_err_255", {24'd0, err_count}, 32'd255);
    end
    check("t6_err_sat", {24'd0, err_count}, 32'd255);
    check("t6_rdy", {31'd0, pipe_enq__RDY}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
